// File: rtl/wfd_pkg.sv
// Shared definitions for the waveform-digitizer merge path: FSM encoding and
// block header field layout.
package wfd_pkg;

  localparam int NCH_DEF = 16;
  localparam int WORD_W  = 16;
  localparam int CNT_W   = 9;

  localparam int HDR_FLAG    = 15;
  localparam int HDR_LEN_MSB = 8;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_CH_MSB  = 14;
  localparam int HDR_CH_LSB  = 9;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_HDR   = 5'b00010,
    S_WAIT  = 5'b00100,
    S_DATA  = 5'b01000,
    S_SPARE = 5'b10000
  } state_t;

  function automatic logic is_hdr(input logic [WORD_W-1:0] w);
    return w[HDR_FLAG];
  endfunction

  function automatic logic [CNT_W-1:0] hdr_len(input logic [WORD_W-1:0] w);
    return w[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/chan_arbiter_if.sv
// Channel-side req/ack/din handshake plus the merged downstream word port.
interface chan_arbiter_if import wfd_pkg::*; #(parameter int NCH = NCH_DEF);

  logic [NCH-1:0]             req;
  logic [NCH-1:0]             ack;
  logic [NCH-1:0][WORD_W-1:0] din;
  logic [WORD_W-1:0]          dout;
  logic                       dwe;
  logic                       dfull;
  logic                       busy;
  logic [15:0]                err_cnt;

  modport slave  (input  req, din, dfull, output ack, dout, dwe, busy, err_cnt);
  modport master (output req, din, dfull, input  ack, dout, dwe, busy, err_cnt);

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester strictly after i_last,
// wrapping NCH-1 -> 0.
module rr_select #(
  parameter  int NCH = 16,
  localparam int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [SW-1:0]  i_last,
  output logic           o_any,
  output logic [SW-1:0]  o_sel
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_any = |i_req;
    o_sel = i_last;
    w_idx = 0;
    for (int off = NCH; off >= 1; off--) begin
      w_idx = (int'(i_last) + off) % NCH;
      if (i_req[SW'(w_idx)]) o_sel = SW'(w_idx);
    end
  end

endmodule

// File: rtl/chan_arbiter.sv
// Merges whole per-channel blocks (header + L data words) into one word
// stream, serving channels round-robin one block per grant.
module chan_arbiter import wfd_pkg::*; #(
  parameter int NCH = NCH_DEF
) (
  input logic         clk,
  input logic         reset,
  chan_arbiter_if.slave bus
);

  localparam int GW = $clog2(NCH);

  state_t            r_state, w_state_n;
  logic [GW-1:0]     r_g, w_g_n;
  logic [GW-1:0]     r_last, w_last_n;
  logic [GW-1:0]     w_sel;
  logic              w_any;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic [WORD_W-1:0] r_dout, w_dout_n;
  logic [WORD_W-1:0] w_din_g;
  logic              r_dwe, w_dwe_n;
  logic              r_busy, w_busy_n;
  logic [NCH-1:0]    r_ack, w_ack_n;
  logic [15:0]       r_err, w_err_n;

  rr_select #(.NCH(NCH)) u_rr (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_any  (w_any),
    .o_sel  (w_sel)
  );

  assign w_din_g = bus.din[r_g];

  // WAIT exists because din lags ack by two edges; every ack is followed by
  // one dead cycle before din[g] is looked at again.
  always_comb begin
    w_state_n = r_state;
    w_g_n     = r_g;
    w_last_n  = r_last;
    w_cnt_n   = r_cnt;
    w_dout_n  = r_dout;
    w_dwe_n   = 1'b0;
    w_ack_n   = '0;
    w_busy_n  = r_busy;
    w_err_n   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_any && !bus.dfull) begin
          w_g_n     = w_sel;
          w_busy_n  = 1'b1;
          w_state_n = S_HDR;
        end
      end
      S_HDR: begin
        if (!bus.dfull) begin
          w_ack_n[r_g] = 1'b1;
          w_state_n    = S_WAIT;
          if (is_hdr(w_din_g)) begin
            w_dout_n = w_din_g;
            w_dwe_n  = 1'b1;
            w_cnt_n  = hdr_len(w_din_g);
          end else begin
            // Stray word (e.g. leftover after a reset): drop it, count it.
            w_cnt_n = '0;
            if (r_err != 16'hFFFF) w_err_n = r_err + 16'd1;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_last_n  = r_g;
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end else begin
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (!bus.dfull && bus.req[r_g]) begin
          w_dout_n     = w_din_g;
          w_dwe_n      = 1'b1;
          w_ack_n[r_g] = 1'b1;
          w_cnt_n      = r_cnt - CNT_W'(1);
          w_state_n    = S_WAIT;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_last  <= GW'(NCH-1);
      r_cnt   <= '0;
      r_dout  <= '0;
      r_dwe   <= 1'b0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_n;
      r_g     <= w_g_n;
      r_last  <= w_last_n;
      r_cnt   <= w_cnt_n;
      r_dout  <= w_dout_n;
      r_dwe   <= w_dwe_n;
      r_ack   <= w_ack_n;
      r_busy  <= w_busy_n;
      r_err   <= w_err_n;
    end
  end

  assign bus.ack     = r_ack;
  assign bus.dout    = r_dout;
  assign bus.dwe     = r_dwe;
  assign bus.busy    = r_busy;
  assign bus.err_cnt = r_err;

endmodule

// File: tb/tb_chan_arbiter.sv
// Directed bench for chan_arbiter: channel FIFO models feed blocks, a
// scoreboard queue holds the words expected on dout in order.
module tb_chan_arbiter;
  import wfd_pkg::*;

  localparam int NCH  = 16;
  localparam int MEMD = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  chan_arbiter_if #(.NCH(NCH)) bus();

  chan_arbiter #(.NCH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Channel FIFO model: registered read, so din moves on the edge after
  // the one at which ack is seen high.
  logic [15:0] mem [NCH][MEMD];
  int          rd [NCH] = '{default: 0};
  int          wr [NCH] = '{default: 0};
  logic [15:0] exp_q [$];

  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      int n;
      n = rd[k] + int'(bus.ack[k]);
      rd[k]      <= n;
      bus.din[k] <= (n < wr[k]) ? mem[k][n] : 16'h0;
      bus.req[k] <= (n < wr[k]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("ack_onehot", 32'($countones(bus.ack) <= 1), 32'd1);
    if (bus.dwe) begin
      chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("dout", {16'h0, bus.dout}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic push_word(input int k, input logic [15:0] w, input bit expect_out);
    mem[k][wr[k]] = w;
    wr[k]++;
    if (expect_out) exp_q.push_back(w);
  endtask

  // Header + L data words; only the first 'keep' words are expected out.
  task automatic push_block(input int k, input int L, input int keep);
    push_word(k, 16'h8000 | 16'(k << 9) | 16'(L), keep > 0);
    for (int i = 1; i <= L; i++)
      push_word(k, 16'((k * 256 + i * 7 + 1) & 32'h7FFF), i < keep);
  endtask

  task automatic drain(input int k, output int nack);
    bit done;
    nack = 0;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (bus.ack[k]) nack++;
      done = (exp_q.size() == 0) && !bus.busy && (bus.req == '0);
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  // busy span is counted edge-inclusive: grant edge through clearing edge.
  task automatic run_block(input int k, input int L, input string tag);
    int t_req, t_hdr, t_d1, b_r, b_f, nack, ndwe, nother;
    t_req = -1; t_hdr = -1; t_d1 = -1; b_r = -1; b_f = -1;
    nack = 0; ndwe = 0; nother = 0;
    @(negedge clk);
    push_block(k, L, L + 1);
    for (int c = 0; c < 3000 && b_f < 0; c++) begin
      @(negedge clk);
      if (t_req < 0 && bus.req[k]) t_req = cyc;
      if (bus.dwe) begin
        ndwe++;
        if (t_hdr < 0) t_hdr = cyc;
        else if (t_d1 < 0) t_d1 = cyc;
      end
      if (bus.ack[k]) nack++;
      if ((bus.ack & ~(NCH'(1) << k)) != '0) nother++;
      if (bus.busy && b_r < 0) b_r = cyc;
      if (!bus.busy && b_r >= 0 && b_f < 0) b_f = cyc;
    end
    chk({tag, "_done"}, 32'(b_f >= 0), 32'd1);
    chk({tag, "_dwe"}, ndwe, L + 1);
    chk({tag, "_ack"}, nack, L + 1);
    chk({tag, "_otherack"}, nother, 0);
    chk({tag, "_hdr_lat"}, t_hdr - t_req, 2);
    if (L > 0) chk({tag, "_d1_lat"}, t_d1 - t_req, 4);
    chk({tag, "_busy"}, b_f - b_r + 1, 2 * L + 3);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},  32'(bus.ack), 32'd0);
    chk({tag, "_dout"}, 32'(bus.dout), 32'd0);
    chk({tag, "_dwe"},  32'(bus.dwe), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_err"},  32'(bus.err_cnt), 32'd0);
  endtask

  initial begin
    int n, nd, viol;
    bus.dfull = 1'b0;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    reset = 1'b0;

    run_block(3, 5, "single");

    // round robin: reset restores last = NCH-1, so ch 0 goes first
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    push_block(0, 2, 3);
    push_block(5, 2, 3);
    push_block(15, 2, 3);
    drain(15, n);
    chk("rr_ack15", n, 3);

    // backpressure before data word 3 of an L=8 block
    @(negedge clk);
    push_block(7, 8, 9);
    nd = 0;
    for (int c = 0; c < 200 && nd < 3; c++) begin
      @(negedge clk);
      if (bus.dwe) nd++;
    end
    chk("bp_reach", nd, 3);
    bus.dfull = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.dwe || bus.ack != '0) viol++;
    end
    bus.dfull = 1'b0;
    chk("bp_quiet", viol, 0);
    drain(7, n);
    chk("bp_ack_rest", n, 6);

    // stray word ahead of a header
    @(negedge clk);
    push_word(2, 16'h0123, 1'b0);
    push_block(2, 1, 2);
    drain(2, n);
    chk("stray_ack", n, 3);
    chk("stray_err", 32'(bus.err_cnt), 32'd1);

    // reset after word 2 of an L=10 block
    @(negedge clk);
    push_block(4, 10, 3);
    push_block(4, 1, 2);
    nd = 0;
    for (int c = 0; c < 200 && nd < 3; c++) begin
      @(negedge clk);
      if (bus.dwe) nd++;
    end
    chk("rst_reach", nd, 3);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rstmid");
    reset = 1'b0;
    drain(4, n);
    chk("rst_ack", n, 10);
    chk("rst_err", 32'(bus.err_cnt), 32'd8);

    run_block(9, 0, "l0");
    run_block(11, 511, "l511");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
